// File: rtl/serial_subtractor_if.sv
// Operand/result bundle between a requester and the serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             carryout;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, carryout, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, carryout, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial two's-complement subtractor: a - b computed as a + ~b + 1,
// one DIGIT-bit slice per clock, LSB slice first, carry rippled in a register.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one slice added per clock, counter 0..NSTEP-1
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  serial_subtractor_if.slave bus
);
  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [DIGIT:0]   sum;
  logic             c_into_msb;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Next-state and slice arithmetic; the carry into the MSB is recovered
  // from the top bit of the last slice (a ^ b ^ sum).
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    sum        = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, carry_q};
    c_into_msb = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ sum[DIGIT-1];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = ~bus.b;
          carry_d = 1'b1;
          cnt_d   = '0;
          work_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        work_d  = {sum[DIGIT-1:0], work_q[WIDTH-1:DIGIT]};
        carry_d = sum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NSTEP - 1)) begin
          diff_d  = {sum[DIGIT-1:0], work_q[WIDTH-1:DIGIT]};
          cout_d  = sum[DIGIT];
          ovf_d   = c_into_msb ^ sum[DIGIT];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.diff     = diff_q;
  assign bus.carryout = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  localparam int W     = 32;
  localparam int NSTEP = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] last_diff = '0;

  serial_subtractor_if #(.WIDTH(W)) bus ();
  serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         c;
    logic         o;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Reference: whole-word arithmetic, overflow by sign rules.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] d, output logic c, output logic o);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    d = s[W-1:0];
    c = s[W];
    o = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
  endtask

  // Called at a negedge in IDLE (or done cycle): present a request.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
  endtask

  // Follows one operation from cycle 1 to the done cycle; optionally
  // injects an extra start pulse in cycle inj with junk operands.
  task automatic track(input string name, input logic [W-1:0] ed, input logic ec,
                       input logic eo, input int inj);
    for (int i = 1; i <= NSTEP; i++) begin
      cyc();
      bus.start = (i == inj);
      if (i == inj) begin
        bus.a = 1;
        bus.b = 1;
      end else begin
        bus.a = $urandom;
        bus.b = $urandom;
      end
      chk({name, " busy"}, {31'b0, bus.busy}, 1);
      chk({name, " done-early"}, {31'b0, bus.done}, 0);
      chk({name, " diff-hold"}, bus.diff, last_diff);
    end
    cyc();
    bus.start = 1'b0;
    chk({name, " done"}, {31'b0, bus.done}, 1);
    chk({name, " busy-at-done"}, {31'b0, bus.busy}, 0);
    chk({name, " diff"}, bus.diff, ed);
    chk({name, " carryout"}, {31'b0, bus.carryout}, {31'b0, ec});
    chk({name, " overflow"}, {31'b0, bus.overflow}, {31'b0, eo});
    last_diff = ed;
  endtask

  task automatic chk_zero(input string name);
    chk({name, " busy"}, {31'b0, bus.busy}, 0);
    chk({name, " done"}, {31'b0, bus.done}, 0);
    chk({name, " diff"}, bus.diff, 0);
    chk({name, " carryout"}, {31'b0, bus.carryout}, 0);
    chk({name, " overflow"}, {31'b0, bus.overflow}, 0);
  endtask

  vec_t vecs[5];

  initial begin
    logic [W-1:0] ra, rb, md;
    logic mc, mo;
    int seen;

    vecs[0] = '{a: 32'd5,          b: 32'd3,          d: 32'h00000002, c: 1'b1, o: 1'b0};
    vecs[1] = '{a: 32'h00000000,   b: 32'h00000001,   d: 32'hFFFFFFFF, c: 1'b0, o: 1'b0};
    vecs[2] = '{a: 32'h80000000,   b: 32'h00000001,   d: 32'h7FFFFFFF, c: 1'b1, o: 1'b1};
    vecs[3] = '{a: 32'h7FFFFFFF,   b: 32'hFFFFFFFF,   d: 32'h80000000, c: 1'b0, o: 1'b1};
    vecs[4] = '{a: 32'h12345678,   b: 32'h00000000,   d: 32'h12345678, c: 1'b1, o: 1'b0};

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;

    // Asynchronous reset before any clock edge.
    #1 reset = 1'b1;
    #1 chk_zero("reset-async");
    cyc();
    cyc();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (bus.busy || bus.done) seen++;
    end
    chk("reset-idle-quiet", seen, 0);
    chk_zero("reset-after-release");

    // Directed table.
    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b);
      track($sformatf("vec%0d", i), vecs[i].d, vecs[i].c, vecs[i].o, 0);
    end

    // Handshake: ignored start mid-run, then back-to-back from done cycle.
    cyc();
    launch(32'd10, 32'd4);
    track("hs-first", 32'd6, 1'b1, 1'b0, 4);
    launch(32'hFFFFFFFF, 32'hFFFFFFFF);
    track("hs-b2b", 32'd0, 1'b1, 1'b0, 0);

    // Reset in cycle 5 of a run.
    cyc();
    launch(32'd100, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      bus.start = 1'b0;
    end
    reset = 1'b1;
    #1 chk_zero("midreset-async");
    cyc();
    reset = 1'b0;
    last_diff = '0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (bus.done || bus.busy) seen++;
    end
    chk("midreset-no-done", seen, 0);
    chk_zero("midreset-outputs");
    launch(32'd9, 32'd2);
    track("after-reset", 32'd7, 1'b1, 1'b0, 0);

    // Randomized back-to-back operations against the reference.
    for (int n = 0; n < 25; n++) begin
      ra = $urandom;
      rb = (n % 5 == 0) ? ra : $urandom;
      if (n % 7 == 3) rb = {1'b1, 31'b0} ^ ($urandom & 32'h0000FFFF);
      model(ra, rb, md, mc, mo);
      launch(ra, rb);
      track($sformatf("rand%0d", n), md, mc, mo, (n % 3 == 0) ? 1 + (n % NSTEP) : 0);
    end

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
